fetch_decode_stage: RTL and testbench

- Stage 1 of the 3-stage processor: program counter, instruction fetch and decode.
- Addresses the instruction ROM, latches the 8-bit instruction and decodes it.
- Drives the data/enable pins of the two 4-bit operand registers (register_half instances A and B).
- Issues ALU opcodes to the execute stage, with a stall input from downstream.

---
 rtl/fetch_decode_stage.sv | 96 +++++++++
 tb/tb_fetch_decode_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// Stage 1: PC, instruction fetch and decode. Strobes appear two cycles after FETCH, one instruction per two cycles.
// A stall_in in DECODE holds pc and ir and delays the strobes one cycle per stall cycle; nothing is dropped.
module fetch_decode_stage #(
  parameter int                  PC_WIDTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                res,
  input  logic                run,
  input  logic [7:0]          instr_in,
  input  logic                stall_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [3:0]          reg_a_d,
  output logic                reg_a_en,
  output logic [3:0]          reg_b_d,
  output logic                reg_b_en,
  output logic [3:0]          alu_op,
  output logic                exec_valid,
  output logic                halted
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, HALT} state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state;
  logic [7:0] ir;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= IDLE;
      ir         <= 8'h00;
      pc_out     <= RESET_PC;
      reg_a_d    <= 4'h0;
      reg_a_en   <= 1'b0;
      reg_b_d    <= 4'h0;
      reg_b_en   <= 1'b0;
      alu_op     <= 4'h0;
      exec_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      // strobes are single-cycle pulses unless re-armed by a DECODE exit below
      reg_a_en   <= 1'b0;
      reg_b_en   <= 1'b0;
      exec_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run) state <= FETCH;
        end
        FETCH: begin
          ir     <= instr_in;
          pc_out <= pc_out + 1'b1;
          state  <= DECODE;
        end
        DECODE: begin
          if (!stall_in) begin
            case (ir[7:4])
              OP_LDA: begin
                reg_a_d  <= ir[3:0];
                reg_a_en <= 1'b1;
              end
              OP_LDB: begin
                reg_b_d  <= ir[3:0];
                reg_b_en <= 1'b1;
              end
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                alu_op     <= ir[7:4];
                exec_valid <= 1'b1;
              end
              OP_JMP: pc_out <= PC_WIDTH'(ir[3:0]);
              default: ;
            endcase
            if (ir[7:4] == OP_HLT) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= run ? FETCH : IDLE;
            end
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: instruction-level reference model compared every cycle,
// plus literal expectations taken from hand-traced programs.
module tb_fetch_decode_stage;

  logic       clk;
  logic       res;
  logic       run;
  logic       stall_in;
  logic [7:0] instr_in;
  logic [3:0] pc_out;
  logic [3:0] reg_a_d, reg_b_d, alu_op;
  logic       reg_a_en, reg_b_en, exec_valid, halted;

  logic [7:0] rom [16];
  assign instr_in = rom[pc_out];

  fetch_decode_stage #(.PC_WIDTH(4), .RESET_PC(4'd0)) dut (
    .clk        (clk),
    .res        (res),
    .run        (run),
    .instr_in   (instr_in),
    .stall_in   (stall_in),
    .pc_out     (pc_out),
    .reg_a_d    (reg_a_d),
    .reg_a_en   (reg_a_en),
    .reg_b_d    (reg_b_d),
    .reg_b_en   (reg_b_en),
    .alu_op     (alu_op),
    .exec_valid (exec_valid),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 fetching, 2 decoding, 3 halted.
  int         m_phase;
  int         m_pc;
  logic [7:0] m_ir;
  int         m_ad, m_bd, m_op;
  logic       m_aen, m_ben, m_ev, m_halted;

  always @(posedge clk or posedge res) begin
    if (res) begin
      m_phase <= 0; m_pc <= 0; m_ir <= 8'h00;
      m_ad <= 0; m_bd <= 0; m_op <= 0;
      m_aen <= 0; m_ben <= 0; m_ev <= 0; m_halted <= 0;
    end else begin
      m_aen <= 0; m_ben <= 0; m_ev <= 0;
      if (m_phase == 0) begin
        if (run) m_phase <= 1;
      end else if (m_phase == 1) begin
        m_ir    <= rom[m_pc];
        m_pc    <= (m_pc + 1) % 16;
        m_phase <= 2;
      end else if (m_phase == 2 && !stall_in) begin
        if (m_ir / 16 == 1) begin
          m_ad <= m_ir % 16; m_aen <= 1;
        end else if (m_ir / 16 == 2) begin
          m_bd <= m_ir % 16; m_ben <= 1;
        end else if (m_ir / 16 >= 3 && m_ir / 16 <= 7) begin
          m_op <= m_ir / 16; m_ev <= 1;
        end else if (m_ir / 16 == 8) begin
          m_pc <= m_ir % 16;
        end
        if (m_ir / 16 == 15) begin
          m_phase <= 3; m_halted <= 1;
        end else begin
          m_phase <= run ? 1 : 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("pc_out", pc_out, m_pc);
    chk("reg_a_d", reg_a_d, m_ad);
    chk("reg_a_en", reg_a_en, m_aen);
    chk("reg_b_d", reg_b_d, m_bd);
    chk("reg_b_en", reg_b_en, m_ben);
    chk("alu_op", alu_op, m_op);
    chk("exec_valid", exec_valid, m_ev);
    chk("halted", halted, m_halted);
    chk("strobe_onehot", (32'(reg_a_en) + 32'(reg_b_en) + 32'(exec_valid)) <= 1, 1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 0; stall_in = 0; res = 1;
    step(); step();
    res = 0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  int exp_pc [5]  = '{0, 1, 1, 2, 2};
  int exp_aen [5] = '{0, 0, 1, 0, 0};
  int exp_ben [5] = '{0, 0, 0, 0, 1};
  int pulses;
  int n;

  initial begin
    res = 1; run = 0; stall_in = 0;
    clear_rom();

    // Reset / idle
    rom[0] = 8'h15;
    do_reset();
    chk("rst_pc", pc_out, 0);
    chk("rst_halted", halted, 0);
    for (int i = 0; i < 10; i++) step();
    chk("idle_pc", pc_out, 0);
    chk("idle_strobes", {reg_a_en, reg_b_en, exec_valid}, 0);

    // Loads
    clear_rom(); rom[0] = 8'h15; rom[1] = 8'h2A;
    do_reset();
    run = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("ld_pc", pc_out, exp_pc[k]);
      chk("ld_aen", reg_a_en, exp_aen[k]);
      chk("ld_ben", reg_b_en, exp_ben[k]);
      if (k == 2) chk("ld_ad", reg_a_d, 5);
      if (k == 4) chk("ld_bd", reg_b_d, 4'hA);
    end
    run = 0;
    step(); step(); step();

    // ALU issue with three stalled DECODE cycles
    clear_rom(); rom[0] = 8'h30;
    do_reset();
    run = 1;
    pulses = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) run = 0;
      if (k == 2) stall_in = 1;
      if (k >= 3 && k <= 5) chk("stall_no_ev", exec_valid, 0);
      if (k == 5) stall_in = 0;
      if (k == 6) begin
        chk("stall_ev", exec_valid, 1);
        chk("stall_op", alu_op, 3);
      end
      if (exec_valid === 1'b1) pulses++;
    end
    chk("stall_pulses", pulses, 1);
    chk("stall_pc", pc_out, 1);

    // Jump to 15, wrap, jump to 7, halt
    clear_rom(); rom[0] = 8'h8F; rom[15] = 8'h13; rom[7] = 8'hF0;
    do_reset();
    run = 1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 3) begin
        chk("jmp_pc15", pc_out, 15);
        rom[0] = 8'h87;
      end
      if (k == 4) chk("wrap_pc", pc_out, 0);
      if (k == 5) begin
        chk("wrap_aen", reg_a_en, 1);
        chk("wrap_ad", reg_a_d, 3);
      end
      if (k == 7) chk("jmp_pc7", pc_out, 7);
    end
    chk("hlt_halted", halted, 1);
    chk("hlt_pc", pc_out, 8);
    for (int k = 0; k < 6; k++) begin
      run = k[0];
      step();
    end
    chk("hlt_hold_pc", pc_out, 8);
    chk("hlt_hold_halted", halted, 1);

    // Asynchronous reset during a reg_b_en pulse
    clear_rom(); rom[0] = 8'h15; rom[1] = 8'h2A;
    do_reset();
    run = 1;
    n = 0;
    while (m_ben !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("rstmid_reached", n < 20, 1);
    chk("rstmid_ben_before", reg_b_en, 1);
    #2;
    res = 1; run = 0;
    #1;
    chk("rstmid_ben", reg_b_en, 0);
    chk("rstmid_pc", pc_out, 0);
    step();
    res = 0;
    for (int k = 0; k < 3; k++) step();
    chk("rstmid_idle_pc", pc_out, 0);
    chk("rstmid_idle_bd", reg_b_d, 0);

    // Unused opcode behaves as NOP
    clear_rom(); rom[0] = 8'hB9;
    do_reset();
    run = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) run = 0;
      chk("nop_strobes", {reg_a_en, reg_b_en, exec_valid}, 0);
    end
    chk("nop_pc", pc_out, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
